egm_stimulus_responder: RTL
===========================

Name: egm_stimulus_responder

Overview:
- Hardware responder for the EGM stimulus/response handshake; it sits at the opposite end from the stimulus generator.
- Watches the asynchronous `stimulus` line, waits a programmable delay, then drives a `response` pulse of programmable width.
- Counts serviced and missed stimuli.
- Gives a deterministic hardware baseline to compare against the Nios polling and interrupt responders. Instantiated beside the Qsys system on the 50 MHz board clock.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on stimulus (legal range 2..4)
- DELAY_W, 16, width of delay_cycles and the delay counter
- PULSE_W, 8, width of pulse_cycles and the pulse counter
- CNT_W, 16, width of resp_count and miss_count

Ports:
- clkin_50  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- stimulus  in  1  asynchronous stimulus from the EGM
- enable  in  1  1 = arm responder; 0 = ignore new stimuli
- delay_cycles  in  DELAY_W  cycles from detected rise to response assertion
- pulse_cycles  in  PULSE_W  response high time in cycles; 0 is treated as 1
- clear_counts  in  1  synchronous clear of both counters
- response  out  1  registered response to the EGM
- busy  out  1  high in any state other than IDLE
- resp_count  out  CNT_W  stimuli serviced
- miss_count  out  CNT_W  rises detected while not IDLE
- state_dbg  out  2  current FSM state encoding

Behaviour:
- Clock and reset: one clock, clkin_50. Reset rst_n is asynchronous, active-low. While rst_n=0:
  - response=0, busy=0, resp_count=0, miss_count=0, state=IDLE(00).
  - Sync chain clears to 0.
- Synchronizer: stimulus passes through SYNC_STAGES flops to give stim_s, then one more flop gives stim_d.
- Rise detection: rise = stim_s & ~stim_d, combinational.
- FSM encodings: IDLE=00, DELAY=01, PULSE=10, WAIT_LOW=11.
- IDLE:
  - On rise & enable, latch delay_cycles into dcnt and max(pulse_cycles,1) into pcnt.
  - If the latched delay is 0, go to PULSE. Otherwise go to DELAY.
  - rise & ~enable: no action, nothing counted.
- DELAY: dcnt decrements each cycle. When dcnt==1, go to PULSE.
- PULSE:
  - response=1 for exactly pcnt cycles.
  - Then response=0 and go to WAIT_LOW. resp_count increments on PULSE exit.
- WAIT_LOW: stay until stim_s==0, then go to IDLE. The responder re-arms only after stimulus deasserts.
- Latency: response rises exactly SYNC_STAGES+1+delay_cycles clock edges after the first edge that samples stimulus=1, provided setup to that edge is met.
- Misses: a rise detected in DELAY, PULSE or WAIT_LOW increments miss_count. The sequence in progress is not disturbed.
- Input latching: delay_cycles and pulse_cycles are sampled only at the accepting rise. Changes mid-sequence have no effect until the next rise.
- Enable dropped mid-sequence: the current sequence completes normally.
- Counters:
  - Both saturate at all-ones; no wrap.
  - clear_counts has priority over a same-cycle increment; the result is 0.
- Reset mid-sequence: response drops asynchronously. After release the FSM is in IDLE.
  - If stimulus is still high at release, the sync chain fills with 1s. stim_d lags stim_s by one cycle, so rise=1 for one cycle.
  - That rise is accepted as a new stimulus if enable=1. This is the intended behaviour.
- busy is registered alongside state: busy = (state != IDLE).

Optional Feature:
- Macro: EGM_RESP_JITTER_EN.
- When defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'h5A on reset) advances every clock.
  - At an accepting rise, the low 4 bits of the LFSR are added to delay_cycles. The sum saturates at 2^DELAY_W-1.
  - This emulates software response jitter of 0..15 cycles.
- When not defined: no LFSR logic is present and the delay is exactly delay_cycles.

Test Plan:
- Basic delay: SYNC_STAGES=2, enable=1, delay_cycles=10, pulse_cycles=4; raise stimulus and hold 50 cycles -> response high on edges 13..16 after first sampling edge, resp_count=1, miss_count=0.
- Zero delay and zero pulse: delay_cycles=0, pulse_cycles=0 -> response rises 3 edges after sampling, high for exactly 1 cycle.
- Miss during busy: delay_cycles=20, pulse_cycles=5; pulse stimulus high 2 cycles, low 3 cycles, high again (both inside DELAY) -> one response, resp_count=1, miss_count=1.
- Disabled and re-arm: enable=0, 3 stimulus pulses -> response stays 0, counts 0. Then enable=1 with stimulus held high through the pulse -> FSM waits in WAIT_LOW, returns to IDLE 1 cycle after stim_s falls.
- Saturation and clear: preload via 65537 serviced stimuli (or force) -> resp_count=16'hFFFF. Assert clear_counts in the same cycle as a PULSE exit -> resp_count=0.
- Reset mid-pulse: assert rst_n=0 during PULSE -> response=0 immediately, counts 0. Release with stimulus high, enable=1 -> the one-cycle rise after release is accepted, and a response follows after delay_cycles.

Source files
------------

// File: rtl/egm_stimulus_responder_if.sv
// Stimulus/response bus between the EGM-side host and the hardware responder.
// master: drives stimulus and configuration; slave: the responder.
interface egm_stimulus_responder_if #(
    parameter int unsigned DELAY_W = 16,
    parameter int unsigned PULSE_W = 8,
    parameter int unsigned CNT_W   = 16
);
    logic               stimulus;
    logic               enable;
    logic [DELAY_W-1:0] delay_cycles;
    logic [PULSE_W-1:0] pulse_cycles;
    logic               clear_counts;
    logic               response;
    logic               busy;
    logic [CNT_W-1:0]   resp_count;
    logic [CNT_W-1:0]   miss_count;
    logic [1:0]         state_dbg;

    modport master (
        output stimulus, enable, delay_cycles, pulse_cycles, clear_counts,
        input  response, busy, resp_count, miss_count, state_dbg
    );

    modport slave (
        input  stimulus, enable, delay_cycles, pulse_cycles, clear_counts,
        output response, busy, resp_count, miss_count, state_dbg
    );
endinterface

// File: rtl/egm_stimulus_responder.sv
// Hardware EGM responder: synchronises stimulus, waits a programmed delay, drives a response pulse.
// Optional build macro EGM_RESP_JITTER_EN adds 0..15 cycles of LFSR jitter to the delay.
module egm_stimulus_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DELAY_W     = 16,
    parameter int unsigned PULSE_W     = 8,
    parameter int unsigned CNT_W       = 16
) (
    input logic                     clkin_50,
    input logic                     rst_n,
    egm_stimulus_responder_if.slave bus
);
    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StDelay   = 2'b01,
        StPulse   = 2'b10,
        StWaitLow = 2'b11
    } state_e;

    state_e               state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 stim_d_q;
    logic                 stim_s;
    logic                 rise;
    logic [DELAY_W-1:0]   dcnt_q, dcnt_d;
    logic [DELAY_W-1:0]   delay_eff;
    logic [PULSE_W-1:0]   pcnt_q, pcnt_d;
    logic                 response_q;
    logic                 busy_q;
    logic [CNT_W-1:0]     resp_count_q, resp_count_d;
    logic [CNT_W-1:0]     miss_count_q, miss_count_d;
    logic                 resp_inc;
    logic                 miss_inc;

    assign stim_s = sync_q[SYNC_STAGES-1];
    assign rise   = stim_s & ~stim_d_q;

`ifdef EGM_RESP_JITTER_EN
    logic [7:0]       lfsr_q;
    logic [DELAY_W:0] delay_sum;

    always_ff @(posedge clkin_50 or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 8'h5A;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    // Extra carry bit detects overflow so the jittered delay saturates instead of wrapping.
    assign delay_sum = {1'b0, bus.delay_cycles} + {{(DELAY_W - 3){1'b0}}, lfsr_q[3:0]};
    assign delay_eff = delay_sum[DELAY_W] ? '1 : delay_sum[DELAY_W-1:0];
`else
    assign delay_eff = bus.delay_cycles;
`endif

    always_comb begin
        state_d  = state_q;
        dcnt_d   = dcnt_q;
        pcnt_d   = pcnt_q;
        resp_inc = 1'b0;
        miss_inc = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rise && bus.enable) begin
                    dcnt_d  = delay_eff;
                    pcnt_d  = (bus.pulse_cycles == '0) ? PULSE_W'(1) : bus.pulse_cycles;
                    state_d = (delay_eff == '0) ? StPulse : StDelay;
                end
            end
            StDelay: begin
                miss_inc = rise;
                dcnt_d   = dcnt_q - DELAY_W'(1);
                if (dcnt_q == DELAY_W'(1)) state_d = StPulse;
            end
            StPulse: begin
                miss_inc = rise;
                pcnt_d   = pcnt_q - PULSE_W'(1);
                if (pcnt_q == PULSE_W'(1)) begin
                    state_d  = StWaitLow;
                    resp_inc = 1'b1;
                end
            end
            StWaitLow: begin
                miss_inc = rise;
                if (!stim_s) state_d = StIdle;
            end
        endcase
    end

    // Clear wins over a same-cycle increment; both counters stick at all-ones.
    always_comb begin
        resp_count_d = resp_count_q;
        miss_count_d = miss_count_q;
        if (bus.clear_counts) begin
            resp_count_d = '0;
            miss_count_d = '0;
        end else begin
            if (resp_inc && (resp_count_q != '1)) resp_count_d = resp_count_q + CNT_W'(1);
            if (miss_inc && (miss_count_q != '1)) miss_count_d = miss_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clkin_50 or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            stim_d_q     <= 1'b0;
            state_q      <= StIdle;
            dcnt_q       <= '0;
            pcnt_q       <= '0;
            response_q   <= 1'b0;
            busy_q       <= 1'b0;
            resp_count_q <= '0;
            miss_count_q <= '0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], bus.stimulus};
            stim_d_q     <= stim_s;
            state_q      <= state_d;
            dcnt_q       <= dcnt_d;
            pcnt_q       <= pcnt_d;
            response_q   <= (state_d == StPulse);
            busy_q       <= (state_d != StIdle);
            resp_count_q <= resp_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign bus.response   = response_q;
    assign bus.busy       = busy_q;
    assign bus.resp_count = resp_count_q;
    assign bus.miss_count = miss_count_q;
    assign bus.state_dbg  = state_q;
endmodule
